// File: rtl/mole_spawner.sv
// Whack-a-mole target generator: spawns random lit targets on a game tick, ages them, scores hits and misses.
// Optional: define MOLE_SPAWNER_SPURIOUS_PENALTY_EN to subtract one point per cycle with a spurious switch edge.
module mole_spawner #(
  parameter int WIDTH      = 18,
  parameter int RND_W      = 5,
  parameter int TICK_DIV   = 50000000,
  parameter int LIFETIME   = 3,
  parameter int MAX_ACTIVE = 4,
  parameter int MAX_TRIES  = 4
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             enable,
  input  logic [RND_W-1:0] rnd,
  input  logic [WIDTH-1:0] edge_detect,
  output logic [WIDTH-1:0] targets,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic             spurious_pulse,
  output logic [7:0]       score,
  output logic [7:0]       misses,
  output logic [3:0]       active_count
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam int PC_W  = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(MAX_TRIES - 1);
  localparam logic [3:0]       AGE_END   = 4'(LIFETIME);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAW
  } state_t;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  state_t           state, state_next;
  logic [TRY_W-1:0] tries, tries_next;
  logic             spawn;
  logic [31:0]      rnd_ext;
  logic [WIDTH-1:0] sel_vec;
  logic             draw_valid;
  logic [WIDTH-1:0] hit_vec, spur_vec, expire_vec, spawn_vec, targets_next;
  logic [3:0]       age [WIDTH];
  logic [3:0]       age_next [WIDTH];
  logic [PC_W-1:0]  hit_cnt, miss_cnt;
  logic [8:0]       score_sum, miss_sum;
  logic [7:0]       score_sat, score_next, misses_next;

  assign tick = enable && (tick_cnt == TICK_LAST);

  // Draw is judged against the registered targets, so a bit clearing this cycle still blocks a spawn.
  always_comb begin
    rnd_ext = 32'(rnd);
    sel_vec = '0;
    for (int j = 0; j < WIDTH; j++) sel_vec[j] = (rnd_ext == 32'(j));
    draw_valid = (rnd_ext < 32'(WIDTH)) && ((targets & sel_vec) == '0);
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state <= IDLE;
      tries <= '0;
    end else begin
      state <= state_next;
      tries <= tries_next;
    end
  end

  always_comb begin
    state_next = state;
    tries_next = tries;
    spawn      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = WAIT;
      end
      WAIT: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (tick && (32'(active_count) < 32'(MAX_ACTIVE))) begin
          state_next = DRAW;
          tries_next = '0;
        end
      end
      DRAW: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (draw_valid) begin
          spawn      = 1'b1;
          state_next = WAIT;
        end else if (tries == TRY_LAST) begin
          state_next = WAIT;
        end else begin
          tries_next = tries + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A hit on a target that would expire on the same tick takes priority over the expiry.
  always_comb begin
    hit_vec      = edge_detect & targets;
    spur_vec     = edge_detect & ~targets;
    spawn_vec    = spawn ? sel_vec : '0;
    expire_vec   = '0;
    targets_next = '0;
    for (int j = 0; j < WIDTH; j++) begin
      expire_vec[j]   = tick && targets[j] && !hit_vec[j] && ((age[j] + 4'd1) == AGE_END);
      targets_next[j] = (targets[j] && !hit_vec[j] && !expire_vec[j]) || spawn_vec[j];
      if (spawn_vec[j] || !targets_next[j]) age_next[j] = 4'd0;
      else if (tick)                        age_next[j] = age[j] + 4'd1;
      else                                  age_next[j] = age[j];
    end
  end

  always_comb begin
    hit_cnt   = popcount(hit_vec);
    miss_cnt  = popcount(expire_vec);
    score_sum = {1'b0, score} + 9'(hit_cnt);
    miss_sum  = {1'b0, misses} + 9'(miss_cnt);
    score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];
    misses_next = miss_sum[8] ? 8'hFF : miss_sum[7:0];
`ifdef MOLE_SPAWNER_SPURIOUS_PENALTY_EN
    score_next = ((spur_vec != '0) && (score_sat != 8'd0)) ? score_sat - 8'd1 : score_sat;
`else
    score_next = score_sat;
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      tick_cnt       <= '0;
      targets        <= '0;
      hit_pulse      <= 1'b0;
      miss_pulse     <= 1'b0;
      spurious_pulse <= 1'b0;
      score          <= 8'd0;
      misses         <= 8'd0;
      active_count   <= 4'd0;
      for (int j = 0; j < WIDTH; j++) age[j] <= 4'd0;
    end else begin
      if (enable) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      targets        <= targets_next;
      hit_pulse      <= (hit_vec != '0);
      miss_pulse     <= (expire_vec != '0);
      spurious_pulse <= (spur_vec != '0);
      score          <= score_next;
      misses         <= misses_next;
      active_count   <= 4'(popcount(targets_next));
      for (int j = 0; j < WIDTH; j++) age[j] <= age_next[j];
    end
  end

endmodule
